seq_divider: RTL and testbench

- Iterative non-restoring divider: the inverse companion of the Booth multiplier.
- Takes an N-bit dividend and divisor on a start pulse and produces an N-bit quotient and remainder after a fixed latency.
- Shares the multiplier's start-pulse launch style and 100 MHz clock, so both blocks sit side by side in the same arithmetic datapath.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 148 ++++++++++++++
 tb/tb_seq_divider.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_t;

    // Wide enough for any practical N; callers slice the low N bits.
    localparam logic [63:0] DIV_ZERO_Q = '1;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational non-restoring shift and add/subtract step
module div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   p,
    input  logic [N-1:0] a,
    input  logic [N-1:0] v,
    output logic [N:0]   p_next,
    output logic [N-1:0] a_next,
    output logic         q_bit
);

    logic [N:0] p_sh;

    assign p_sh = {p[N-1:0], a[N-1]};

    // The sign of the partial remainder before the shift selects the operation.
    always_comb begin
        if (p[N]) begin
            p_next = p_sh + {1'b0, v};
        end else begin
            p_next = p_sh - {1'b0, v};
        end
    end

    assign q_bit  = ~p_next[N];
    assign a_next = {a[N-2:0], 1'b0};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative non-restoring divider; DIV_SIGNED_EN selects two's-complement operands
module seq_divider
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk_100MHz,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] data_inD,
    input  logic [N-1:0] data_inV,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CNT_W = cnt_width(N);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [N:0]         p;
    logic [N-1:0]       a;
    logic [N-1:0]       v_mag;
    logic [N:0]         p_step;
    logic [N-1:0]       a_step;
    logic               q_bit;
    logic               zero_div;
    logic [N-1:0]       d_mag_in;
    logic [N-1:0]       v_mag_in;
    logic [N-1:0]       r_mag;
    logic [N-1:0]       q_res;
    logic [N-1:0]       r_res;

    assign zero_div = (data_inV == '0);

    // A negative partial remainder is restored once, after the last step.
    assign r_mag = p[N] ? (p[N-1:0] + v_mag) : p[N-1:0];

`ifdef DIV_SIGNED_EN
    logic d_neg;
    logic v_neg;

    assign d_mag_in = data_inD[N-1] ? -data_inD : data_inD;
    assign v_mag_in = data_inV[N-1] ? -data_inV : data_inV;
    assign q_res    = (d_neg ^ v_neg) ? -a : a;
    assign r_res    = d_neg ? -r_mag : r_mag;
`else
    assign d_mag_in = data_inD;
    assign v_mag_in = data_inV;
    assign q_res    = a;
    assign r_res    = r_mag;
`endif

    div_step #(.N(N)) u_step (
        .p      (p),
        .a      (a),
        .v      (v_mag),
        .p_next (p_step),
        .a_next (a_step),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            p           <= '0;
            a           <= '0;
            v_mag       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            d_neg       <= 1'b0;
            v_neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && zero_div) begin
                        quotient    <= DIV_ZERO_Q[N-1:0];
                        remainder   <= data_inD;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        p     <= '0;
                        a     <= d_mag_in;
                        v_mag <= v_mag_in;
                        cnt   <= CNT_W'(N);
`ifdef DIV_SIGNED_EN
                        d_neg <= data_inD[N-1];
                        v_neg <= data_inV[N-1];
`endif
                    end
                end
                CALC: begin
                    p   <= p_step;
                    a   <= a_step | {{(N-1){1'b0}}, q_bit};
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    quotient    <= q_res;
                    remainder   <= r_res;
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider (either DIV_SIGNED_EN build)
module tb_seq_divider;

    localparam int N = 8;

    logic         clk_100MHz = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] data_inD = '0;
    logic [N-1:0] data_inV = '0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.N(N)) dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .start       (start),
        .data_inD    (data_inD),
        .data_inV    (data_inV),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic void ref_div(input logic [7:0] d, input logic [7:0] v,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic z);
        int di;
        int vi;
        if (v == 8'h00) begin
            q = 8'hFF;
            r = d;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            di = $signed(d);
            vi = $signed(v);
`else
            di = int'(d);
            vi = int'(v);
`endif
            q = 8'(di / vi);
            r = 8'(di % vi);
            z = 1'b0;
        end
    endfunction

    task automatic run_op(input logic [7:0] d, input logic [7:0] v, output int lat,
                          output logic [7:0] q, output logic [7:0] r, output logic z);
        @(posedge clk_100MHz); #1;
        start    = 1'b1;
        data_inD = d;
        data_inV = v;
        @(posedge clk_100MHz); #1;
        start    = 1'b0;
        data_inD = 8'($urandom);
        data_inV = 8'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk_100MHz); #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs q=%h r=%h busy=%b done=%b dbz=%b required all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        repeat (2) @(posedge clk_100MHz);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] td [4];
        logic [7:0] tv [4];
        logic [7:0] tq [4];
        logic [7:0] tr [4];
        int lat;
        logic [7:0] q, r;
        logic z;
`ifdef DIV_SIGNED_EN
        td = '{8'hD6, 8'h9C, 8'h64, 8'h80};
        tv = '{8'h07, 8'h07, 8'h07, 8'hFF};
        tq = '{8'hFA, 8'hF2, 8'h0E, 8'h80};
        tr = '{8'h00, 8'hFE, 8'h02, 8'h00};
`else
        td = '{8'hFA, 8'h64, 8'hFF, 8'h80};
        tv = '{8'h07, 8'h07, 8'h01, 8'hFF};
        tq = '{8'h23, 8'h0E, 8'hFF, 8'h00};
        tr = '{8'h05, 8'h02, 8'h00, 8'h80};
`endif
        for (int i = 0; i < 4; i++) begin
            run_op(td[i], tv[i], lat, q, r, z);
            checks++;
            if (lat !== N + 2 || q !== tq[i] || r !== tr[i] || z !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d d=%h v=%h got lat=%0d q=%h r=%h z=%b required lat=%0d q=%h r=%h z=0",
                         i, td[i], tv[i], lat, q, r, z, N + 2, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_zero_div();
        int lat;
        logic [7:0] q, r;
        logic z;
        run_op(8'h05, 8'h00, lat, q, r, z);
        checks++;
        if (lat !== 1 || q !== 8'hFF || r !== 8'h05 || z !== 1'b1) begin
            errors++;
            $display("FAIL zero_div got lat=%0d q=%h r=%h z=%b required lat=1 q=ff r=05 z=1", lat, q, r, z);
        end
        run_op(8'h64, 8'h07, lat, q, r, z);
        checks++;
        if (lat !== N + 2 || q !== 8'h0E || r !== 8'h02 || z !== 1'b0) begin
            errors++;
            $display("FAIL zero_div_clear got lat=%0d q=%h r=%h z=%b required lat=%0d q=0e r=02 z=0",
                     lat, q, r, z, N + 2);
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] prev_q;
        int cyc;
        prev_q = quotient;
        @(posedge clk_100MHz); #1;
        start = 1'b1; data_inD = 8'h64; data_inV = 8'h07;
        @(posedge clk_100MHz); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_cycle1 busy=%b done=%b required busy=1 done=0", busy, done);
        end
        @(posedge clk_100MHz); #1;
        @(posedge clk_100MHz); #1;
        start = 1'b1; data_inD = 8'h03; data_inV = 8'h02;
        checks++;
        if (quotient !== prev_q) begin
            errors++;
            $display("FAIL hold_during_calc q=%h required %h", quotient, prev_q);
        end
        @(posedge clk_100MHz); #1;
        start = 1'b0;
        cyc = 4;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk_100MHz); #1;
            cyc++;
        end
        checks++;
        if (cyc !== N + 2 || quotient !== 8'h0E || remainder !== 8'h02) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d q=%h r=%h required lat=%0d q=0e r=02",
                     cyc, quotient, remainder, N + 2);
        end
        @(posedge clk_100MHz); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_done busy=%b done=%b required busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [7:0] q, r, eq, er;
        logic z, ez;
        bit saw_done;
        @(posedge clk_100MHz); #1;
        start = 1'b1; data_inD = 8'hD6; data_inV = 8'h07;
        @(posedge clk_100MHz); #1;
        start = 1'b0;
        repeat (4) @(posedge clk_100MHz);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid q=%h r=%h busy=%b done=%b dbz=%b required all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk_100MHz); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done done pulse seen=1 required 0");
        end
        rst_n = 1'b1;
        run_op(8'hD6, 8'h07, lat, q, r, z);
        ref_div(8'hD6, 8'h07, eq, er, ez);
        checks++;
        if (lat !== N + 2 || q !== eq || r !== er || z !== ez) begin
            errors++;
            $display("FAIL relaunch got lat=%0d q=%h r=%h z=%b required lat=%0d q=%h r=%h z=%b",
                     lat, q, r, z, N + 2, eq, er, ez);
        end
    endtask

    task automatic test_random();
        int lat, elat;
        logic [7:0] d, v, q, r, eq, er;
        logic z, ez;
        for (int i = 0; i < 60; i++) begin
            d = 8'($urandom);
            v = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            if (i == 0) v = 8'h01;
            if (i == 1) v = 8'hFF;
            run_op(d, v, lat, q, r, z);
            ref_div(d, v, eq, er, ez);
            elat = (v == 8'h00) ? 1 : N + 2;
            checks++;
            if (lat !== elat || q !== eq || r !== er || z !== ez) begin
                errors++;
                $display("FAIL random_%0d d=%h v=%h got lat=%0d q=%h r=%h z=%b required lat=%0d q=%h r=%h z=%b",
                         i, d, v, lat, q, r, z, elat, eq, er, ez);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_div();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
